arm_mac_seq: RTL

- Parametrised, multi-cycle successor to the single-cycle MAC unit in the ARM core.
- Computes MUL/MLA (WIDTH-bit result) and UMULL/UMLAL/SMULL/SMLAL (2*WIDTH-bit result) with a radix-2^RADIX_LOG2 shift-add datapath.
- Uses a ready/start/done handshake so the core can stall decode while a multiply is in flight.
- Produces N/Z flag values for the CPSR update path.

---
 rtl/arm_mac_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/arm_mac_seq.sv
// Multi-cycle shift-add multiply/accumulate unit for MUL/MLA and the long
// multiplies, with a ready/start/done handshake and N/Z flag outputs.
module arm_mac_seq #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RADIX_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             flush,
  input  logic             op_long,
  input  logic             op_signed,
  input  logic             op_acc,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int unsigned K    = WIDTH / RADIX_LOG2;
  localparam int unsigned CntW = $clog2(K + 1);
  localparam int unsigned W2   = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StFixup, StDone} state_e;

  state_e            state_q, state_d;
  logic [W2-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [W2-1:0]     prod_q, prod_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              long_q, long_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  res_lo_q, res_lo_d;
  logic [WIDTH-1:0]  res_hi_q, res_hi_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_z_q, flag_z_d;

  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [W2-1:0]     acc_in;
  logic [W2-1:0]     partial;
  logic [W2-1:0]     fixed;
  logic [W2-1:0]     sum;

  // Signedness only matters for the long forms; the low word is sign-agnostic.
  assign a_neg  = op_signed & op_long & op_a[WIDTH-1];
  assign b_neg  = op_signed & op_long & op_b[WIDTH-1];
  // The most-negative value negates to itself, which is the correct magnitude.
  assign mag_a  = a_neg ? (~op_a + WIDTH'(1)) : op_a;
  assign mag_b  = b_neg ? (~op_b + WIDTH'(1)) : op_b;
  assign acc_in = !op_acc ? '0 : (op_long ? {acc_hi, acc_lo} : {{WIDTH{1'b0}}, acc_lo});

  assign fixed  = neg_q ? (~prod_q + W2'(1)) : prod_q;
  assign sum    = fixed + acc_q;

  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < RADIX_LOG2; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    long_d   = long_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          prod_d   = '0;
          acc_d    = acc_in;
          neg_d    = a_neg ^ b_neg;
          long_d   = op_long;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          prod_d   = prod_q + partial;
          mcand_d  = mcand_q << RADIX_LOG2;
          mplier_d = mplier_q >> RADIX_LOG2;
          cnt_d    = cnt_q + CntW'(1);
          if (cnt_q == CntW'(K - 1)) state_d = StFixup;
        end
      end
      StFixup: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          res_lo_d = sum[WIDTH-1:0];
          res_hi_d = long_q ? sum[W2-1:WIDTH] : '0;
          flag_n_d = long_q ? sum[W2-1] : sum[WIDTH-1];
          flag_z_d = long_q ? (sum == '0) : (sum[WIDTH-1:0] == '0);
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      long_q   <= 1'b0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      long_q   <= long_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign ready  = (state_q == StIdle) || (state_q == StDone);
  assign busy   = (state_q == StRun) || (state_q == StFixup);
  assign done   = (state_q == StDone);
  assign res_lo = res_lo_q;
  assign res_hi = res_hi_q;
  assign flag_n = flag_n_q;
  assign flag_z = flag_z_q;

endmodule
